// File: rtl/macc_pkg.sv
// Shared parameters and helpers for the MACC accumulate/requantize stage.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package macc_pkg;

    // Default datapath geometry: 3x3 kernel, 16-bit products, 8-bit activations.
    localparam int PROD_W_DEF = 16;
    localparam int TAPS_DEF   = 9;
    localparam int ACC_W_DEF  = 24;
    localparam int OUT_W_DEF  = 8;
    localparam int SHIFT_DEF  = 7;

    // Bits needed to count 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Largest signed value representable in out_w bits.
    function automatic longint sat_max(input int out_w);
        return (longint'(1) << (out_w - 1)) - longint'(1);
    endfunction

    // Smallest signed value representable in out_w bits.
    function automatic longint sat_min(input int out_w);
        return -(longint'(1) << (out_w - 1));
    endfunction

endpackage

// File: rtl/macc_requant.sv
// Round-half-up, optional ReLU and saturation of a window sum to an activation.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module macc_requant
    import macc_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT   = SHIFT_DEF,
    parameter bit RELU_EN = 1'b0
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    // One guard bit so adding the rounding constant never wraps the sum.
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(longint'(1) << (SHIFT - 1));
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(sat_max(OUT_W));
    localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(sat_min(OUT_W));

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] shifted;
    logic signed [EXT_W-1:0] clamped;

    // Round, then ReLU, then clip; ReLU never counts as a saturation event.
    always_comb begin
        ext     = signed'({sum[ACC_W-1], sum});
        rnd     = ext + HALF;
        shifted = rnd >>> SHIFT;

        clamped = shifted;
        if (RELU_EN && shifted[EXT_W-1]) begin
            clamped = '0;
        end

        data = clamped[OUT_W-1:0];
        sat  = 1'b0;
        if (clamped > MAX_V) begin
            data = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (clamped < MIN_V) begin
            data = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/macc_accum.sv
// Accumulates TAPS signed products plus bias per window and emits a requantized activation.
// Latency: result valid the cycle after the last tap is accepted.
// Backpressure: only the last tap stalls, and only while an unconsumed result is held.
module macc_accum
    import macc_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int TAPS    = TAPS_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT   = SHIFT_DEF,
    parameter bit RELU_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ACC_W-1:0]  bias,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_in,
    output logic              prod_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat
);

    localparam int               CNT_W    = clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic [CNT_W-1:0] tap_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic             first_tap;
    logic             last_tap;
    logic             hold;
    logic             xfer;
    logic [OUT_W-1:0] rq_data;
    logic             rq_sat;

    assign prod_ext = {{(ACC_W - PROD_W){prod_in[PROD_W-1]}}, prod_in};

    // Handshake and next-sum; prod_valid only gates state updates, never an output.
    always_comb begin
        first_tap  = (tap_cnt == '0);
        last_tap   = (tap_cnt == LAST_TAP);
        hold       = out_valid && !out_ready;
        prod_ready = !(last_tap && hold);
        xfer       = prod_valid && prod_ready;
        base       = first_tap ? bias : acc;
        sum        = base + prod_ext;
    end

    macc_requant #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .RELU_EN (RELU_EN)
    ) u_requant (
        .sum  (sum),
        .data (rq_data),
        .sat  (rq_sat)
    );

    // Tap counter and running sum advance on every accepted product.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (xfer) begin
            acc     <= sum;
            tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
        end
    end

    // Output register: loads on the last tap (even while handing off the old result).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
        end else if (xfer && last_tap) begin
            out_valid <= 1'b1;
            out_data  <= rq_data;
            out_acc   <= sum;
            out_sat   <= rq_sat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_macc_accum.sv
// Scoreboard bench for macc_accum: two instances (ReLU off/on) share one stimulus stream.
// Latency: checks the result appears the cycle after the last tap.
// Backpressure: random and directed out_ready stalls, prod_ready predicted every cycle.
module tb_macc_accum;

    localparam int TAPS  = 9;
    localparam int SHIFT = 7;
    localparam longint OMAX = 127;
    localparam longint OMIN = -128;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bias;
    logic        prod_valid;
    logic [15:0] prod_in;
    logic        out_ready;

    logic        pr0, pr1, ov0, ov1, os0, os1;
    logic [7:0]  od0, od1;
    logic [23:0] oa0, oa1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        longint acc;
        longint data;
        bit     sat;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     due_q[$];
    longint win[$];
    longint win_bias;
    int     hold_cnt   = 0;
    bit     rand_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    macc_accum #(.RELU_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bias(bias), .prod_valid(prod_valid), .prod_in(prod_in),
        .prod_ready(pr0), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_acc(oa0), .out_sat(os0)
    );

    macc_accum #(.RELU_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bias(bias), .prod_valid(prod_valid), .prod_in(prod_in),
        .prod_ready(pr1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_acc(oa1), .out_sat(os1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: window sum wraps to 24 bits, then floor((sum + 2^(SHIFT-1)) / 2^SHIFT).
    function automatic exp_t reference(input longint total, input bit relu);
        exp_t        e;
        logic [23:0] w;
        longint      r;
        w     = total[23:0];
        e.acc = longint'(signed'(w));
        r     = (e.acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (relu && r < 0) r = 0;
        e.sat = 1'b0;
        if (r > OMAX) begin
            r = OMAX; e.sat = 1'b1;
        end else if (r < OMIN) begin
            r = OMIN; e.sat = 1'b1;
        end
        e.data = r;
        return e;
    endfunction

    task automatic accept(input logic [15:0] v);
        longint total;
        if (win.size() == 0) win_bias = longint'(signed'(bias));
        win.push_back(longint'(signed'(v)));
        if (win.size() == TAPS) begin
            total = win_bias;
            foreach (win[i]) total += win[i];
            q0.push_back(reference(total, 1'b0));
            q1.push_back(reference(total, 1'b1));
            due_q.push_back(cyc + 1);
            win.delete();
        end
    endtask

    // One cycle: drive at posedge+1, predict/observe prod_ready at posedge+3.
    task automatic step(input logic [15:0] v, input logic vld, output bit took);
        bit exp_pr;
        prod_valid = vld;
        prod_in    = v;
        if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #2;
        exp_pr = !(win.size() == TAPS - 1 && q0.size() > 0 && !out_ready);
        chk("prod_ready", longint'(pr0), longint'(exp_pr));
        chk("prod_ready_relu", longint'(pr1), longint'(exp_pr));
        took = vld && pr0;
        if (took) accept(v);
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] v);
        bit took;
        int n;
        n = 0;
        do begin
            step(v, 1'b1, took);
            n++;
        end while (!took && n < 200);
        if (!took) chk("put_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit took;
        repeat (n) step(16'h0, 1'b0, took);
    endtask

    task automatic do_reset();
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        hold_cnt   = 0;
        rst        = 1'b1;
        win.delete();
        q0.delete();
        q1.delete();
        due_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_out_valid", longint'(ov0) + longint'(ov1), 0);
        chk("rst_out_data", longint'(od0) + longint'(od1), 0);
        chk("rst_out_acc", longint'(oa0) + longint'(oa1), 0);
        chk("rst_out_sat", longint'(os0) + longint'(os1), 0);
        chk("rst_prod_ready", longint'(pr0 & pr1), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input bit id, input logic v, input logic [7:0] d,
                             input logic [23:0] a, input logic s);
        exp_t e;
        if (!v) return;
        if ((id ? q1.size() : q0.size()) == 0) begin
            chk(id ? "unexpected_out_relu" : "unexpected_out", 1, 0);
            return;
        end
        e = id ? q1[0] : q0[0];
        chk(id ? "out_acc_relu" : "out_acc", longint'(signed'(a)), e.acc);
        chk(id ? "out_data_relu" : "out_data", longint'(signed'(d)), e.data);
        chk(id ? "out_sat_relu" : "out_sat", longint'(s), longint'(e.sat));
        if (out_ready) begin
            if (id) void'(q1.pop_front());
            else    void'(q0.pop_front());
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            while (due_q.size() > 0 && due_q[0] == cyc) begin
                chk("latency_valid", longint'(ov0), 1);
                chk("latency_valid_relu", longint'(ov1), 1);
                void'(due_q.pop_front());
            end
            check_out(1'b0, ov0, od0, oa0, os0);
            check_out(1'b1, ov1, od1, oa1, os1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        bit took;
        rst        = 1'b1;
        bias       = '0;
        prod_valid = 1'b0;
        prod_in    = '0;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Small sum 1..9.
        for (int i = 1; i <= TAPS; i++) put(16'(i));
        idle(3);
        // Positive saturation.
        repeat (TAPS) put(16'd16384);
        idle(3);
        // Negative saturation (ReLU instance clamps to 0 without sat).
        repeat (TAPS) put(-16'sd16384);
        idle(3);
        // Bias + rounding with bubbles on alternate cycles.
        bias = 24'd256;
        for (int i = 0; i < TAPS; i++) begin
            step(16'h0, 1'b0, took);
            put(16'd128);
        end
        bias = '0;
        idle(3);
        // Backpressure: second window's last tap must stall behind the held result.
        for (int i = 0; i < TAPS; i++) begin
            put(16'd128);
            if (i == TAPS - 1) hold_cnt = 12;
        end
        repeat (TAPS) put(16'd128);
        idle(4);
        // Reset mid-window discards the partial sum.
        repeat (4) put(16'd1000);
        do_reset();
        repeat (TAPS) put(16'd128);
        idle(3);

        // Randomized windows: bias changes every tap, random bubbles and stalls.
        rand_ready = 1'b1;
        for (int w = 0; w < 60; w++) begin
            if (w == 30) begin
                repeat (3) put(16'(int'($urandom_range(0, 200))));
                do_reset();
            end
            if ($urandom_range(0, 7) == 0) hold_cnt = int'($urandom_range(1, 15));
            for (int t = 0; t < TAPS; t++) begin
                bias = 24'($urandom);
                case ($urandom_range(0, 2))
                    0:       x = int'($urandom_range(0, 600)) - 300;
                    1:       x = $urandom_range(0, 1) ? 16384 - int'($urandom_range(0, 100)) : -16384;
                    default: x = int'($urandom_range(0, 65535)) - 32768;
                endcase
                if ($urandom_range(0, 3) == 0) step(16'h0, 1'b0, took);
                put(x[15:0]);
            end
        end

        // Drain everything still outstanding.
        rand_ready = 1'b0;
        hold_cnt   = 0;
        for (int i = 0; i < 50 && (q0.size() > 0 || q1.size() > 0); i++) idle(1);
        idle(2);
        chk("drain_results", longint'(q0.size() + q1.size()), 0);
        chk("drain_due", longint'(due_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
